// File: rtl/cube_defs_pkg.sv
// Board-wide defaults for the LED cube, shared by the pattern source,
// the panel driver and the top level.
package cube_defs_pkg;

    // Total bits in the daisy-chained panel shift registers.
    localparam int PANEL_CHAIN_LEN = 16;
    // clk cycles per serial-clock half period at the 50 MHz board clock.
    localparam int PANEL_CLK_DIV   = 4;

endpackage

// File: rtl/phase_timer.sv
// Down-counter that times one phase of CLK_DIV cycles. Load on the first
// cycle of a phase; expired is high on the phase's last cycle.
module phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic expired
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= CNT_W'(CLK_DIV - 1);
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/panel_shift_driver.sv
// Serialises one pattern word MSB-first onto the panel shift-register chain
// with a divided serial clock, then pulses the storage latch.
module panel_shift_driver
    import cube_defs_pkg::*;
#(
    parameter int DATA_WIDTH = PANEL_CHAIN_LEN,
    parameter int CLK_DIV    = PANEL_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  sclk,
    output logic                  sdata,
    output logic                  latch,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    // Handshake: a word transfers on any clk edge where data_valid and
    // data_ready are both high; data_ready is high only in IDLE, and the
    // upstream keeps data_valid/data_in stable until that edge.

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  phase_done;

    phase_timer #(.CLK_DIV(CLK_DIV)) u_phase_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state_d != state_q),
        .expired (phase_done)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (data_valid && data_ready) begin
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
                    state_d   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_done) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (phase_done) begin
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d = LATCH;
                    end else begin
                        shreg_d   = shreg_q << 1;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        state_d   = SHIFT_LO;
                    end
                end
            end
            LATCH: begin
                if (phase_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state and sdata only moves at a low-phase start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            sclk       <= 1'b0;
            sdata      <= 1'b0;
            latch      <= 1'b0;
            busy       <= 1'b0;
            data_ready <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk       <= (state_d == SHIFT_HI);
            sdata      <= ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ?
                          shreg_d[DATA_WIDTH-1] : 1'b0;
            latch      <= (state_d == LATCH);
            busy       <= (state_d != IDLE);
            data_ready <= (state_d == IDLE);
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_panel_shift_driver.sv
// Bench for panel_shift_driver: timing model derived from cycle offsets,
// a word scoreboard on the serial stream, and a CLK_DIV=1/DATA_WIDTH=1 corner.
module tb_panel_shift_driver;

    localparam int DW   = 8;
    localparam int CD   = 2;
    localparam int XFER = (2 * DW + 1) * CD;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          data_ready, sclk, sdata, latch, busy;
    logic [1:0]    state_dbg;

    logic       b_data_in, b_valid;
    logic       b_ready, b_sclk, b_sdata, b_latch, b_busy;
    logic [1:0] b_state_dbg;

    panel_shift_driver #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .sclk(sclk), .sdata(sdata), .latch(latch),
        .busy(busy), .state_dbg(state_dbg)
    );

    panel_shift_driver #(.DATA_WIDTH(1), .CLK_DIV(1)) dut_min (
        .clk(clk), .reset_n(reset_n), .data_in(b_data_in), .data_valid(b_valid),
        .data_ready(b_ready), .sclk(b_sclk), .sdata(b_sdata), .latch(b_latch),
        .busy(b_busy), .state_dbg(b_state_dbg)
    );

    int cyc       = 0;
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    bit            m_active = 1'b0;
    int            m_t0     = 0;
    logic [DW-1:0] m_word   = '0;
    logic [DW-1:0] exp_q[$];

    function automatic bit m_ready(input int c);
        return !m_active || (c - m_t0 - 1) >= XFER;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0;
            exp_q.delete();
        end else begin
            if (m_ready(cyc) && data_valid) begin
                m_active = 1'b1;
                m_t0     = cyc;
                m_word   = data_in;
                exp_q.push_back(data_in);
            end
            cyc++;
        end
    end

    task automatic model_out(output logic e_sclk, output logic e_sdata, output logic e_latch,
                             output logic e_busy, output logic e_ready);
        int k;
        k = cyc - m_t0 - 1;
        e_sclk = 0; e_sdata = 0; e_latch = 0; e_busy = 0; e_ready = 1;
        if (m_active && k < XFER) begin
            e_busy  = 1;
            e_ready = 0;
            if (k < 2 * CD * DW) begin
                e_sclk  = (k % (2 * CD)) >= CD;
                e_sdata = m_word[DW - 1 - k / (2 * CD)];
            end else begin
                e_latch = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        logic e_sclk, e_sdata, e_latch, e_busy, e_ready;
        if (reset_n) begin
            model_out(e_sclk, e_sdata, e_latch, e_busy, e_ready);
            check("sclk",       sclk,       e_sclk);
            check("sdata",      sdata,      e_sdata);
            check("latch",      latch,      e_latch);
            check("busy",       busy,       e_busy);
            check("data_ready", data_ready, e_ready);
        end
    end

    // ---------------- serial-stream scoreboard ----------------
    logic          prev_sclk = 1'b0, prev_latch = 1'b0;
    logic [DW-1:0] shift_acc = '0, last_word = '0;
    int            rise_cnt = 0, latch_cnt = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            rise_cnt   = 0;
            prev_sclk  = 1'b0;
            prev_latch = 1'b0;
        end else begin
            if (sclk && !prev_sclk) begin
                shift_acc = {shift_acc[DW-2:0], sdata};
                rise_cnt++;
            end
            if (latch && !prev_latch) begin
                latch_cnt++;
                last_word = shift_acc;
                check("edges_per_word", rise_cnt, DW);
                check("sb_depth", exp_q.size(), 1);
                if (exp_q.size() != 0) check("sb_word", shift_acc, exp_q.pop_front());
                rise_cnt = 0;
            end
            prev_sclk  = sclk;
            prev_latch = latch;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic goto_cyc(input int c);
        int n;
        n = 0;
        while (cyc < c && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (cyc < c) check("goto_timeout", cyc, c);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sclk"},  sclk,       0);
        check({tag, "_sdata"}, sdata,      0);
        check({tag, "_latch"}, latch,      0);
        check({tag, "_busy"},  busy,       0);
        check({tag, "_ready"}, data_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0, lc, n;
        reset_n    = 1'b0;
        data_valid = 1'b1;
        data_in    = DW'($urandom);
        b_valid    = 1'b1;
        b_data_in  = 1'b1;

        // Reset held with data_valid asserted: nothing may be accepted.
        repeat (5) begin
            @(posedge clk);
            #2;
            check_reset_values("rst");
            check("rst_min_busy",  b_busy,  0);
            check("rst_min_ready", b_ready, 1);
        end
        data_valid = 1'b0;
        b_valid    = 1'b0;
        reset_n    = 1'b1;

        // Corner: DATA_WIDTH=1, CLK_DIV=1.
        goto_cyc(cyc + 1);
        t0 = cyc; b_data_in = 1'b1; b_valid = 1'b1;
        goto_cyc(t0 + 1); b_valid = 1'b0;
        check("min_lo_sclk", b_sclk, 0);
        check("min_lo_sdata", b_sdata, 1);
        check("min_lo_busy", b_busy, 1);
        goto_cyc(t0 + 2);
        check("min_hi_sclk", b_sclk, 1);
        check("min_hi_sdata", b_sdata, 1);
        goto_cyc(t0 + 3);
        check("min_latch", b_latch, 1);
        check("min_latch_sclk", b_sclk, 0);
        goto_cyc(t0 + 4);
        check("min_ready", b_ready, 1);
        check("min_latch_off", b_latch, 0);
        check("min_busy_off", b_busy, 0);

        // A5 transfer, with data_valid toggling and data_in=3C while busy.
        goto_cyc(cyc + 1);
        t0 = cyc; lc = latch_cnt; data_in = 8'hA5; data_valid = 1'b1;
        goto_cyc(t0 + 1); data_valid = 1'b0;
        check("a5_ready_drop", data_ready, 0);
        for (int c = t0 + 2; c <= t0 + 31; c++) begin
            goto_cyc(c);
            if (c == t0 + 2) check("a5_first_lo", sclk, 0);
            if (c == t0 + 3) check("a5_first_rise", sclk, 1);
            data_valid = 1'($urandom_range(0, 1));
            data_in    = 8'h3C;
        end
        data_valid = 1'b0;
        goto_cyc(t0 + 32); check("a5_pre_latch", latch, 0);
        goto_cyc(t0 + 33); check("a5_latch_start", latch, 1);
        goto_cyc(t0 + 34); check("a5_latch_end", latch, 1);
        goto_cyc(t0 + 35);
        check("a5_ready_back", data_ready, 1);
        check("a5_latch_off", latch, 0);
        check("a5_word", last_word, 8'hA5);
        check("a5_one_latch", latch_cnt - lc, 1);

        // Back-to-back FF then 00 with data_valid held high.
        goto_cyc(cyc + 2);
        t0 = cyc; lc = latch_cnt; data_in = 8'hFF; data_valid = 1'b1;
        goto_cyc(t0 + 1); data_in = 8'h00;
        goto_cyc(t0 + 35); check("b2b_ready", data_ready, 1);
        goto_cyc(t0 + 36); data_valid = 1'b0;
        check("b2b_no_gap_busy", busy, 1);
        check("b2b_no_gap_ready", data_ready, 0);
        goto_cyc(t0 + 70);
        check("b2b_ready_end", data_ready, 1);
        check("b2b_two_latches", latch_cnt - lc, 2);
        check("b2b_zero_word", last_word, 8'h00);

        // Reset after the third sclk rising edge.
        goto_cyc(cyc + 1);
        t0 = cyc; lc = latch_cnt; data_in = DW'($urandom); data_valid = 1'b1;
        goto_cyc(t0 + 1); data_valid = 1'b0;
        n = 0;
        while (rise_cnt < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("third_edge_seen", rise_cnt, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        repeat (2) @(posedge clk);
        #2;
        check_reset_values("held_rst");
        reset_n = 1'b1;
        goto_cyc(cyc + 1);
        check("post_rst_ready", data_ready, 1);
        check("abort_no_latch", latch_cnt - lc, 0);
        t0 = cyc; data_in = 8'h81; data_valid = 1'b1;
        goto_cyc(t0 + 1); data_valid = 1'b0;
        goto_cyc(t0 + 35);
        check("after_rst_word", last_word, 8'h81);
        check("after_rst_latch", latch_cnt - lc, 1);

        // Randomised traffic, with noise on data_valid/data_in while busy.
        for (int i = 0; i < 20; i++) begin
            goto_cyc(cyc + $urandom_range(0, 3));
            n = 0;
            while (!m_ready(cyc) && n < 100) begin
                goto_cyc(cyc + 1);
                n++;
            end
            t0 = cyc; data_in = DW'($urandom); data_valid = 1'b1;
            for (int c = t0 + 1; c < t0 + XFER; c++) begin
                goto_cyc(c);
                data_valid = 1'($urandom_range(0, 1));
                data_in    = DW'($urandom);
            end
        end
        data_valid = 1'b0;
        goto_cyc(cyc + XFER + 4);
        check("final_idle_ready", data_ready, 1);
        check("final_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
